// File: rtl/spram_pkg.sv
// Shared types and size helpers for the banked single-port SRAM controller.
package spram_pkg;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } state_e;

  function automatic int unsigned calc_num_seg(int unsigned width, int unsigned seg_w);
    return width / seg_w;
  endfunction

  function automatic int unsigned calc_addr_w(int unsigned depth);
    return $clog2(depth);
  endfunction

  // A single bank still needs a one-bit select so the port is never zero width.
  function automatic int unsigned calc_bank_w(int unsigned banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

endpackage

// File: rtl/spram_bank.sv
// One behavioural WIDTH x DEPTH single-port array with segment write mask and
// a registered read port.
module spram_bank
  import spram_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 2048,
  parameter int unsigned SEG_W   = 8,
  localparam int unsigned NUM_SEG = calc_num_seg(WIDTH, SEG_W),
  localparam int unsigned ADDR_W  = calc_addr_w(DEPTH)
) (
  input  logic               clk_i,
  input  logic               cen_i,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [WIDTH-1:0]   wdata_i,
  input  logic [NUM_SEG-1:0] seg_mask_i,
  output logic [WIDTH-1:0]   rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // The read register only moves on a read, so a held response stays stable.
  always_ff @(posedge clk_i) begin
    if (cen_i) begin
      if (we_i) begin
        for (int s = 0; s < NUM_SEG; s++) begin
          if (seg_mask_i[s]) begin
            mem_q[addr_i][s*SEG_W +: SEG_W] <= wdata_i[s*SEG_W +: SEG_W];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/banked_spram_ctrl.sv
// Banked single-port SRAM controller: valid/ready request and response channels,
// 1-cycle read latency, per-segment write mask and optional zeroing sweep after reset.
module banked_spram_ctrl
  import spram_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 2048,
  parameter int unsigned NUM_BANKS = 2,
  parameter int unsigned SEG_W     = 8,
  parameter bit          INIT_ZERO = 1'b1,
  localparam int unsigned NUM_SEG  = calc_num_seg(WIDTH, SEG_W),
  localparam int unsigned ADDR_W   = calc_addr_w(DEPTH),
  localparam int unsigned BANK_W   = calc_bank_w(NUM_BANKS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [BANK_W-1:0]  req_bank,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  input  logic [NUM_SEG-1:0] req_seg_mask,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic               rsp_err,
  output logic               init_done
);

  // Response bookkeeping; read data itself lives in the bank read registers.
  typedef struct packed {
    logic              valid;
    logic              err;
    logic              rd;
    logic [BANK_W-1:0] bank;
  } rsp_t;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              init_done_q;
  rsp_t              rsp_q;

  logic in_init;
  logic accept;
  logic oob;

  assign in_init   = (state_q == StInit);
  assign req_ready = (state_q == StRun) && (!rsp_q.valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign oob       = 32'(req_bank) >= NUM_BANKS;

  logic [ADDR_W-1:0]  bank_addr;
  logic [WIDTH-1:0]   bank_wdata;
  logic [NUM_SEG-1:0] bank_mask;
  logic               bank_we;
  logic [NUM_BANKS-1:0] bank_cen;
  logic [WIDTH-1:0]   bank_rdata [NUM_BANKS];

  always_comb begin
    bank_addr  = in_init ? cnt_q : req_addr;
    bank_wdata = in_init ? '0 : req_wdata;
    bank_mask  = in_init ? '1 : req_seg_mask;
    bank_we    = in_init || req_we;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_cen[b] = in_init || (accept && !oob && (req_bank == BANK_W'(b)));
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    spram_bank #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .SEG_W (SEG_W)
    ) u_bank (
      .clk_i      (clk),
      .cen_i      (bank_cen[b]),
      .we_i       (bank_we),
      .addr_i     (bank_addr),
      .wdata_i    (bank_wdata),
      .seg_mask_i (bank_mask),
      .rdata_o    (bank_rdata[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT_ZERO ? StInit : StRun;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      case (state_q)
        StInit: begin
          cnt_q <= cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q     <= StRun;
            init_done_q <= 1'b1;
          end
        end
        StRun: begin
          init_done_q <= 1'b1;
          if (accept) begin
            rsp_q.valid <= 1'b1;
            rsp_q.err   <= oob;
            rsp_q.rd    <= !req_we && !oob;
            rsp_q.bank  <= req_bank;
          end else if (rsp_ready) begin
            rsp_q <= '0;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  always_comb begin
    rsp_rdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rsp_q.rd && (rsp_q.bank == BANK_W'(b))) begin
        rsp_rdata = bank_rdata[b];
      end
    end
  end

  assign rsp_valid = rsp_q.valid;
  assign rsp_err   = rsp_q.err;
  assign init_done = init_done_q;

endmodule
